// File: rtl/nand_target_emu.sv
// NAND flash target emulator: decodes nCE/CLE/ALE/nWE/nRE latch cycles against a register-based array.
// Optional NAND_EMU_WP_EN: nWP low at a program/erase confirm blocks the array update and sets the fail bit.
module nand_target_emu #(
  parameter int PAGE_BYTES      = 16,
  parameter int NUM_PAGES       = 8,
  parameter int PAGES_PER_BLOCK = 4,
  parameter int BUSY_CYCLES     = 32
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       nCE,
  input  logic       CLE,
  input  logic       ALE,
  input  logic       nWE,
  input  logic       nRE,
  input  logic       nWP,
  input  logic [7:0] IO_IN,
  output logic [7:0] IO_OUT,
  output logic       IO_OE,
  output logic       RB
);
  localparam int CW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
  localparam int RW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int BW = $clog2(PAGES_PER_BLOCK);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DIN, S_BUSY, S_DOUT} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_ID, OP_READ, OP_PROG, OP_ERASE, OP_RST} op_t;
  typedef enum logic [1:0] {RD_PAGE, RD_ID, RD_STAT} rd_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  rd_t           rd_q, rd_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    acnt_q, acnt_d, idp_q, idp_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          fail_q, fail_d;
  logic [5:0]    s1_q, s2_q;
  logic          we_prev_q, re_prev_q;
  logic          oe_q, oe_d;
  logic [7:0]    out_q, out_d;
  logic [7:0]    buf_q [PAGE_BYTES];
  logic [7:0]    mem_q [NUM_PAGES][PAGE_BYTES];
  logic          buf_fill, buf_wr, buf_load, arr_prog, arr_erase;
  logic          cle_s, ale_s, nce_s, nwe_s, nre_s, nwp_s;
  logic          latch, re_rise, rb, wp_hit;
  logic [7:0]    status, rd_byte;

  assign {nwp_s, nre_s, nwe_s, nce_s, ale_s, cle_s} = s2_q;
  assign latch   = nwe_s & ~we_prev_q & ~nce_s;
  assign re_rise = nre_s & ~re_prev_q & ~nce_s & (state_q == S_DOUT);
  assign rb      = (state_q != S_BUSY);
  assign status  = {nwp_s, rb, 5'b00000, fail_q};

`ifdef NAND_EMU_WP_EN
  assign wp_hit = ~nwp_s;
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    rd_byte = buf_q[col_q];
    case (rd_q)
      RD_STAT: rd_byte = status;
      RD_ID:   rd_byte = (idp_q == 2'd0) ? 8'hEC : (idp_q == 2'd1) ? 8'hA5 : 8'h00;
      default: rd_byte = buf_q[col_q];
    endcase
  end

  // Status may be polled while busy, so the drive enable also covers BUSY in status mode.
  assign oe_d  = ~nce_s & ~nre_s & ((state_q == S_DOUT) | ((state_q == S_BUSY) & (rd_q == RD_STAT)));
  assign out_d = oe_d ? rd_byte : 8'h00;

  always_comb begin
    state_d = state_q; op_d = op_q; rd_d = rd_q; col_d = col_q; row_d = row_q;
    acnt_d = acnt_q; idp_d = idp_q; cnt_d = cnt_q; fail_d = fail_q;
    buf_fill = 1'b0; buf_wr = 1'b0; buf_load = 1'b0; arr_prog = 1'b0; arr_erase = 1'b0;

    if (state_q == S_BUSY) begin
      if (cnt_q == '0) begin
        case (op_q)
          OP_READ:  buf_load  = 1'b1;
          OP_PROG:  arr_prog  = 1'b1;
          OP_ERASE: arr_erase = 1'b1;
          default: ;
        endcase
        state_d = (op_q == OP_READ || rd_q == RD_STAT) ? S_DOUT : S_IDLE;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end

    if (re_rise) begin
      if (rd_q == RD_PAGE) col_d = col_q + 1'b1;
      else if (rd_q == RD_ID && idp_q != 2'd2) idp_d = idp_q + 2'd1;
    end

    if (latch && cle_s && !ale_s) begin
      if (IO_IN == 8'hFF) begin
        state_d = S_BUSY; op_d = OP_RST; rd_d = RD_PAGE; cnt_d = 16'd3; fail_d = 1'b0;
      end else if (IO_IN == 8'h70) begin
        rd_d = RD_STAT;
        if (state_d != S_BUSY) state_d = S_DOUT;
      end else if (state_q != S_BUSY) begin
        state_d = S_IDLE; op_d = OP_NONE; rd_d = RD_PAGE; acnt_d = 2'd0;
        case (IO_IN)
          8'h90: begin state_d = S_ADDR; op_d = OP_ID; end
          8'h00: begin state_d = S_ADDR; op_d = OP_READ; end
          8'h80: begin state_d = S_ADDR; op_d = OP_PROG; buf_fill = 1'b1; end
          8'h60: begin state_d = S_ADDR; op_d = OP_ERASE; end
          8'h30: if (state_q == S_ADDR && op_q == OP_READ && acnt_q == 2'd2) begin
            state_d = S_BUSY; op_d = OP_READ; cnt_d = 16'(BUSY_CYCLES - 1);
          end
          8'h10: if (state_q == S_DIN && op_q == OP_PROG) begin
            state_d = S_BUSY; op_d = wp_hit ? OP_NONE : OP_PROG;
            cnt_d = 16'(BUSY_CYCLES - 1); fail_d = wp_hit;
          end
          8'hD0: if (state_q == S_ADDR && op_q == OP_ERASE && acnt_q == 2'd1) begin
            state_d = S_BUSY; op_d = wp_hit ? OP_NONE : OP_ERASE;
            cnt_d = 16'(BUSY_CYCLES - 1); fail_d = wp_hit;
          end
          default: ;
        endcase
      end
    end else if (latch && ale_s && !cle_s && state_q == S_ADDR) begin
      case (op_q)
        OP_ID: begin state_d = S_DOUT; rd_d = RD_ID; idp_d = 2'd0; end
        OP_READ, OP_PROG: begin
          if (acnt_q == 2'd0) begin
            col_d = IO_IN[CW-1:0]; acnt_d = 2'd1;
          end else if (acnt_q == 2'd1) begin
            row_d = IO_IN[RW-1:0]; acnt_d = 2'd2;
            if (op_q == OP_PROG) state_d = S_DIN;
          end
        end
        OP_ERASE: if (acnt_q == 2'd0) begin row_d = IO_IN[RW-1:0]; acnt_d = 2'd1; end
        default: ;
      endcase
    end else if (latch && !ale_s && !cle_s && state_q == S_DIN) begin
      buf_wr = 1'b1;
      col_d  = col_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE; op_q <= OP_NONE; rd_q <= RD_PAGE;
      col_q <= '0; row_q <= '0; acnt_q <= 2'd0; idp_q <= 2'd0; cnt_q <= '0; fail_q <= 1'b0;
      s1_q <= 6'b111100; s2_q <= 6'b111100; we_prev_q <= 1'b1; re_prev_q <= 1'b1;
      oe_q <= 1'b0; out_q <= 8'h00;
    end else begin
      state_q <= state_d; op_q <= op_d; rd_q <= rd_d;
      col_q <= col_d; row_q <= row_d; acnt_q <= acnt_d; idp_q <= idp_d; cnt_q <= cnt_d; fail_q <= fail_d;
      s1_q <= {nWP, nRE, nWE, nCE, ALE, CLE}; s2_q <= s1_q;
      we_prev_q <= nwe_s; re_prev_q <= nre_s;
      oe_q <= oe_d; out_q <= out_d;
    end
  end

  // Whole-page operations complete in the final busy cycle, so RB rising implies the array is settled.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      buf_q <= '{default: 8'hFF};
      mem_q <= '{default: '{default: 8'hFF}};
    end else begin
      if (buf_fill) buf_q <= '{default: 8'hFF};
      if (buf_wr) buf_q[col_q] <= IO_IN;
      for (int i = 0; i < PAGE_BYTES; i++) begin
        if (buf_load) buf_q[CW'(i)] <= mem_q[row_q][CW'(i)];
        if (arr_prog) mem_q[row_q][CW'(i)] <= mem_q[row_q][CW'(i)] & buf_q[CW'(i)];
        for (int p = 0; p < NUM_PAGES; p++)
          if (arr_erase && ((RW'(p) >> BW) == (row_q >> BW))) mem_q[RW'(p)][CW'(i)] <= 8'hFF;
      end
    end
  end

  assign IO_OUT = out_q;
  assign IO_OE  = oe_q;
  assign RB     = rb;
endmodule

// File: tb/tb_nand_target_emu.sv
// Directed bench for nand_target_emu: ID, program/read, AND/erase, wrap, status/abort, WP, nCE gating.
module tb_nand_target_emu;
  logic       PCLK = 1'b0, PRESET = 1'b1;
  logic       nCE = 1'b1, CLE = 1'b0, ALE = 1'b0, nWE = 1'b1, nRE = 1'b1, nWP = 1'b1;
  logic [7:0] IO_IN = 8'h00;
  logic [7:0] IO_OUT;
  logic       IO_OE, RB;
  int n_cmp = 0, n_bad = 0;

  always #5 PCLK = ~PCLK;

  nand_target_emu dut (
    .PCLK(PCLK), .PRESET(PRESET), .nCE(nCE), .CLE(CLE), .ALE(ALE), .nWE(nWE),
    .nRE(nRE), .nWP(nWP), .IO_IN(IO_IN), .IO_OUT(IO_OUT), .IO_OE(IO_OE), .RB(RB)
  );

  task automatic wr(input logic c, input logic a, input logic [7:0] d);
    @(negedge PCLK); CLE = c; ALE = a; IO_IN = d; nWE = 1'b0;
    repeat (4) @(negedge PCLK);
    nWE = 1'b1;
    repeat (4) @(negedge PCLK);
    CLE = 1'b0; ALE = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d);  wr(1'b1, 1'b0, d); endtask
  task automatic addr(input logic [7:0] d); wr(1'b0, 1'b1, d); endtask
  task automatic din(input logic [7:0] d);  wr(1'b0, 1'b0, d); endtask

  // Latch a command, then count cycles of RB low until it returns high (bounded).
  task automatic cmd_busy(input logic [7:0] d, output int low);
    @(negedge PCLK); CLE = 1'b1; ALE = 1'b0; IO_IN = d; nWE = 1'b0;
    repeat (4) @(negedge PCLK);
    nWE = 1'b1;
    low = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge PCLK);
      if (!RB) low++;
      else if (low > 0) break;
    end
    CLE = 1'b0;
  endtask

  task automatic rd(output logic [7:0] v, output logic oe);
    @(negedge PCLK); nRE = 1'b0;
    repeat (4) @(negedge PCLK);
    v = IO_OUT; oe = IO_OE;
    nRE = 1'b1;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic prog1(input logic [7:0] col, input logic [7:0] row, input logic [7:0] d, output int low);
    cmd(8'h80); addr(col); addr(row); din(d); cmd_busy(8'h10, low);
  endtask

  task automatic page_open(input logic [7:0] col, input logic [7:0] row, output int low);
    cmd(8'h00); addr(col); addr(row); cmd_busy(8'h30, low);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    for (k = 0; k < 200 && !RB; k++) @(negedge PCLK);
    n_cmp++; if (RB !== 1'b1) begin n_bad++; $display("FAIL %s_ready: RB=%b, want 1", tag, RB); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge PCLK);
    n_cmp++; if (IO_OUT !== 8'h00) begin n_bad++; $display("FAIL rst_io_out: got %h want 00", IO_OUT); end
    n_cmp++; if (IO_OE !== 1'b0) begin n_bad++; $display("FAIL rst_io_oe: got %b want 0", IO_OE); end
    n_cmp++; if (RB !== 1'b1) begin n_bad++; $display("FAIL rst_rb: got %b want 1", RB); end
    PRESET = 1'b0; nCE = 1'b0;
    repeat (4) @(negedge PCLK);
    n_cmp++; if (RB !== 1'b1 || IO_OE !== 1'b0 || IO_OUT !== 8'h00) begin
      n_bad++; $display("FAIL post_rst: RB=%b OE=%b OUT=%h want 1 0 00", RB, IO_OE, IO_OUT); end
  endtask

  task automatic test_read_id;
    logic [7:0] v; logic oe;
    cmd(8'h90); addr(8'h00);
    rd(v, oe);
    n_cmp++; if (v !== 8'hEC || oe !== 1'b1) begin n_bad++; $display("FAIL id0: got %h oe %b want EC oe 1", v, oe); end
    rd(v, oe);
    n_cmp++; if (v !== 8'hA5) begin n_bad++; $display("FAIL id1: got %h want A5", v); end
    rd(v, oe);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL id2: got %h want 00", v); end
    n_cmp++; if (RB !== 1'b1) begin n_bad++; $display("FAIL id_rb: got %b want 1", RB); end
  endtask

  task automatic test_program_read;
    logic [7:0] v; logic oe; int low;
    cmd(8'h80); addr(8'h02); addr(8'h05); din(8'h12); din(8'h34);
    cmd_busy(8'h10, low);
    n_cmp++; if (low != 32) begin n_bad++; $display("FAIL prog_busy: got %0d want 32", low); end
    page_open(8'h02, 8'h05, low);
    n_cmp++; if (low != 32) begin n_bad++; $display("FAIL read_busy: got %0d want 32", low); end
    rd(v, oe);
    n_cmp++; if (v !== 8'h12) begin n_bad++; $display("FAIL pr_b2: got %h want 12", v); end
    rd(v, oe);
    n_cmp++; if (v !== 8'h34) begin n_bad++; $display("FAIL pr_b3: got %h want 34", v); end
    rd(v, oe);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL pr_b4: got %h want FF", v); end
  endtask

  task automatic test_and_erase;
    logic [7:0] v; logic oe; int low;
    prog1(8'h00, 8'h05, 8'h0F, low);
    prog1(8'h00, 8'h05, 8'hF0, low);
    page_open(8'h00, 8'h05, low); rd(v, oe);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL and_sem: got %h want 00", v); end
    prog1(8'h00, 8'h03, 8'h5A, low);
    prog1(8'h00, 8'h07, 8'h00, low);
    cmd(8'h60); addr(8'h05); cmd_busy(8'hD0, low);
    n_cmp++; if (low != 32) begin n_bad++; $display("FAIL erase_busy: got %0d want 32", low); end
    page_open(8'h00, 8'h05, low); rd(v, oe);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL erase_p5c0: got %h want FF", v); end
    rd(v, oe); rd(v, oe);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL erase_p5c2: got %h want FF", v); end
    page_open(8'h00, 8'h07, low); rd(v, oe);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL erase_p7: got %h want FF", v); end
    page_open(8'h00, 8'h04, low); rd(v, oe);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL erase_p4: got %h want FF", v); end
    page_open(8'h00, 8'h03, low); rd(v, oe);
    n_cmp++; if (v !== 8'h5A) begin n_bad++; $display("FAIL erase_p3_kept: got %h want 5A", v); end
  endtask

  task automatic test_col_wrap;
    logic [7:0] v; logic oe; int low;
    cmd(8'h80); addr(8'h0F); addr(8'h02); din(8'hAA); din(8'hBB); cmd_busy(8'h10, low);
    page_open(8'h0F, 8'h02, low);
    rd(v, oe);
    n_cmp++; if (v !== 8'hAA) begin n_bad++; $display("FAIL wrap_b15: got %h want AA", v); end
    rd(v, oe);
    n_cmp++; if (v !== 8'hBB) begin n_bad++; $display("FAIL wrap_b0: got %h want BB", v); end
    rd(v, oe);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL wrap_b1: got %h want FF", v); end
  endtask

  task automatic test_status_abort;
    logic [7:0] v; logic oe; int low;
    cmd(8'h80); addr(8'h00); addr(8'h06); din(8'h11); cmd(8'h10);
    cmd(8'h70); rd(v, oe);
    n_cmp++; if (v !== 8'h80 || oe !== 1'b1) begin n_bad++; $display("FAIL stat_busy: got %h oe %b want 80 oe 1", v, oe); end
    n_cmp++; if (RB !== 1'b0) begin n_bad++; $display("FAIL stat_busy_rb: got %b want 0", RB); end
    wait_ready("stat");
    rd(v, oe);
    n_cmp++; if (v !== 8'hC0) begin n_bad++; $display("FAIL stat_done: got %h want C0", v); end
    cmd_busy(8'hFF, low);
    n_cmp++; if (low != 4) begin n_bad++; $display("FAIL rst_busy: got %0d want 4", low); end
    cmd(8'h70); rd(v, oe);
    n_cmp++; if (v !== 8'hC0) begin n_bad++; $display("FAIL stat_after_rst: got %h want C0", v); end
    cmd(8'h80); addr(8'h01); addr(8'h06); din(8'h22); cmd(8'h10);
    cmd_busy(8'hFF, low);
    wait_ready("abort");
    page_open(8'h00, 8'h06, low);
    rd(v, oe);
    n_cmp++; if (v !== 8'h11) begin n_bad++; $display("FAIL abort_c0: got %h want 11", v); end
    rd(v, oe);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL abort_c1: got %h want FF", v); end
  endtask

  task automatic test_write_protect;
    logic [7:0] v, exp_stat, exp_data; logic oe; int low;
`ifdef NAND_EMU_WP_EN
    exp_stat = 8'h41; exp_data = 8'hFF;
`else
    exp_stat = 8'h40; exp_data = 8'h00;
`endif
    nWP = 1'b0;
    prog1(8'h00, 8'h01, 8'h00, low);
    n_cmp++; if (low != 32) begin n_bad++; $display("FAIL wp_busy: got %0d want 32", low); end
    cmd(8'h70); rd(v, oe);
    n_cmp++; if (v !== exp_stat) begin n_bad++; $display("FAIL wp_status: got %h want %h", v, exp_stat); end
    page_open(8'h00, 8'h01, low); rd(v, oe);
    n_cmp++; if (v !== exp_data) begin n_bad++; $display("FAIL wp_data: got %h want %h", v, exp_data); end
    nWP = 1'b1;
  endtask

  task automatic test_nce_gating;
    int low;
    @(negedge PCLK); nCE = 1'b1;
    cmd_busy(8'hFF, low);
    n_cmp++; if (low != 0) begin n_bad++; $display("FAIL nce_latch: got %0d busy cycles want 0", low); end
    @(negedge PCLK); nRE = 1'b0;
    repeat (5) @(negedge PCLK);
    n_cmp++; if (IO_OE !== 1'b0) begin n_bad++; $display("FAIL nce_oe: got %b want 0", IO_OE); end
    nRE = 1'b1;
    repeat (4) @(negedge PCLK);
    nCE = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic test_bad_confirm;
    logic [7:0] v; logic oe; int low;
    cmd_busy(8'h10, low);
    n_cmp++; if (low != 0) begin n_bad++; $display("FAIL stray_confirm_busy: got %0d want 0", low); end
    rd(v, oe);
    n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL stray_confirm_idle: oe %b want 0", oe); end
  endtask

  initial begin
    test_reset();
    test_read_id();
    test_program_read();
    test_and_erase();
    test_col_wrap();
    test_status_abort();
    test_write_protect();
    test_nce_gating();
    test_bad_confirm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nand_target_emu.md
# nand_target_emu

Synthesizable NAND flash target emulator: the device-side end of the NAND pin interface (nCE/CLE/ALE/nWE/nRE/nWP/IO) driven by the APB NAND controller. It holds a small register-based flash array. It decodes command, address and data latch cycles and drives read data, status, ID and ready/busy back to the controller. It lets the controller be brought up and regression-tested on the SmartFusion2 fabric without a physical flash part.

## Interface
- PAGE_BYTES, 16: bytes per page; power of 2, at most 256.
- NUM_PAGES, 8: pages in the array; power of 2, at most 256.
- PAGES_PER_BLOCK, 4: pages per erase block; power of 2, divides NUM_PAGES.
- BUSY_CYCLES, 32: PCLK cycles RB stays low for page read, program and erase.
- PCLK  in  1  system clock; all logic on its rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- nCE  in  1  chip enable, active-low.
- CLE  in  1  command latch enable.
- ALE  in  1  address latch enable.
- nWE  in  1  write strobe; latch on rising edge.
- nRE  in  1  read strobe; data driven while low.
- nWP  in  1  write protect, active-low.
- IO_IN  in  8  host-to-device bus.
- IO_OUT  out  8  device-to-host bus.
- IO_OE  out  1  IO_OUT drive enable for the top-level tristate.
- RB  out  1  ready/busy (1 = ready).

## Operation
- Pins nCE, CLE, ALE, nWE, nRE and nWP pass through 2-FF synchronizers. IO_IN is sampled in the same cycle the synced nWE rising edge is detected.
- A latch cycle is a synced nWE 0→1 edge while synced nCE = 0:
  - CLE = 1, ALE = 0: command byte.
  - ALE = 1, CLE = 0: address byte.
  - CLE = ALE = 0: data byte.
  - CLE = ALE = 1: ignored.
- FSM states: IDLE, ADDR, DIN, BUSY, DOUT. Supported commands:
  - 0xFF reset: from any state, aborts the current operation. BUSY for 4 cycles, then IDLE. Fail bit cleared. Array content already committed is kept.
  - 0x90 read ID: one address byte (value ignored), then DOUT with bytes 0xEC, 0xA5, then 0x00 repeated.
  - 0x70 read status: DOUT of the status byte, re-evaluated on every read. Accepted in BUSY without leaving BUSY.
    - bit7 = synced nWP.
    - bit6 = RB.
    - bit0 = fail bit.
    - Other bits are 0.
  - 0x00 page read: column byte, row byte, then 0x30. Row is used modulo NUM_PAGES and column modulo PAGE_BYTES. BUSY_CYCLES of busy copy the page into the page buffer, then DOUT starts at the column.
  - 0x80 program: the page buffer is filled with 0xFF, then column byte and row byte. In DIN, each data byte writes buffer[col] and increments col modulo PAGE_BYTES (wraps, overwrites). 0x10 enters BUSY, which ANDs the buffer into the array page (bits go 1→0 only). Fail bit cleared.
  - 0x60 erase: one row byte, then 0xD0. BUSY sets every page of the aligned block containing the row to 0xFF. Fail bit cleared.
- DOUT behaviour:
  - IO_OE = 1 while synced nCE = 0 and synced nRE = 0; IO_OUT holds the current byte.
  - A synced nRE 0→1 edge advances the pointer. The page pointer wraps modulo PAGE_BYTES.
  - Any new command latch leaves DOUT.
- Command-sequence error handling:
  - Any command other than 0xFF or 0x70 received while in BUSY is ignored.
  - An unknown command, or a confirm command (0x30/0x10/0xD0) outside its sequence, returns the FSM to IDLE with no array change.
- nCE = 1 blocks latch cycles and forces IO_OE = 0. It does not reset the FSM.

## Timing
- Reset values: IO_OUT = 0x00, IO_OE = 0, RB = 1, state IDLE, fail bit 0, page buffer 0xFF, array all 0xFF.
- Host must hold each nWE/nRE level for at least 3 PCLK cycles.
- The latch takes effect 3 PCLK after the nWE pin rises.
- IO_OUT and IO_OE are valid 3 PCLK after the nRE pin falls.
- RB goes to 0 on the cycle after the confirm latch. It stays 0 for exactly BUSY_CYCLES (4 for 0xFF). The array update is complete when RB returns to 1.
- Status read during BUSY returns bit6 = 0. The first status read after completion returns bit6 = 1.

## Configuration
- NAND_EMU_WP_EN defined: when synced nWP = 0 at a 0x10 or 0xD0 confirm:
  - The array is not modified.
  - The fail bit is set.
  - The normal BUSY_CYCLES busy period still occurs.
- NAND_EMU_WP_EN undefined: nWP affects only status bit7; program and erase always proceed.

## Test plan
- Reset then read ID: PRESET pulse; cmd 0x90, addr 0x00, three nRE pulses -> IO_OUT = 0xEC, 0xA5, 0x00; RB = 1 throughout.
- Program/read-back: cmd 0x80, col 0x02, row 0x05, data 0x12, 0x34, cmd 0x10 -> RB low for exactly 32 cycles. Then 0x00/0x02/0x05/0x30, wait for RB, 3 reads -> 0x12, 0x34, 0xFF.
- AND semantics and erase: program 0x0F then 0xF0 at the same location -> read 0x00. Erase row 0x05 (0x60/0x05/0xD0) -> pages 4..7 read 0xFF; page 3 is unchanged.
- Column wrap: program col 0x0F with bytes 0xAA, 0xBB -> byte 15 = 0xAA, byte 0 = 0xBB.
- Status during busy and abort: start a program, issue 0x70 mid-busy -> 0x80. Then 0xFF -> RB low for 4 cycles, then status 0xC0.
- Write protect (NAND_EMU_WP_EN): nWP = 0, program 0x00 to page 1 -> status 0x41, page reads 0xFF. Without the macro, the same stimulus -> page reads 0x00 and status 0x40.
